// File: rtl/sweep_pkg.sv
// Shared definitions for the exhaustive sweep capture block: FSM states,
// default MISR constants and the record layout streamed to the logger.
package sweep_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      EMIT  = 2'd2,
      DONE  = 2'd3
   } sweep_state_e;

   localparam logic [15:0] SIG_POLY_DEFAULT = 16'h1021;
   localparam logic [15:0] SIG_SEED_DEFAULT = 16'hFFFF;

   localparam int unsigned REC_PAT_WIDTH = 8;

   typedef struct packed {
      logic [REC_PAT_WIDTH-1:0] pattern;
      logic                     out_bit;
   } sweep_record_t;

endpackage

// File: rtl/exhaustive_sweep_capture_if.sv
// Record stream from the sweep sequencer to a downstream logger.
interface exhaustive_sweep_capture_if #(
   parameter int unsigned N_WIDTH = 8
);
   logic               rec_valid;
   logic               rec_ready;
   logic [N_WIDTH-1:0] rec_pattern;
   logic               rec_bit;

   modport master (
      output rec_valid,
      output rec_pattern,
      output rec_bit,
      input  rec_ready
   );

   modport slave (
      input  rec_valid,
      input  rec_pattern,
      input  rec_bit,
      output rec_ready
   );
endinterface

// File: rtl/sweep_misr.sv
// Multiple-input signature register: seeds on request, otherwise folds one
// zero-extended data word into the signature per enabled cycle.
module sweep_misr
   import sweep_pkg::*;
#(
   parameter int unsigned          SIG_WIDTH  = 16,
   parameter int unsigned          DATA_WIDTH = 9,
   parameter logic [SIG_WIDTH-1:0] SIG_POLY   = SIG_POLY_DEFAULT,
   parameter logic [SIG_WIDTH-1:0] SIG_SEED   = SIG_SEED_DEFAULT
) (
   input  logic                  CK,
   input  logic                  reset,
   input  logic                  seed,
   input  logic                  en,
   input  logic [DATA_WIDTH-1:0] data,
   output logic [SIG_WIDTH-1:0]  sig
);

   logic [SIG_WIDTH-1:0] sig_step;

   always_comb begin
      sig_step = {sig[SIG_WIDTH-2:0], 1'b0} ^ SIG_WIDTH'(data);
      if (sig[SIG_WIDTH-1]) begin
         sig_step = sig_step ^ SIG_POLY;
      end
   end

   always_ff @(posedge CK) begin
      if (reset) begin
         sig <= SIG_SEED;
      end else if (seed) begin
         sig <= SIG_SEED;
      end else if (en) begin
         sig <= sig_step;
      end
   end

endmodule

// File: rtl/exhaustive_sweep_capture.sv
// Exhaustive sweep sequencer: walks every input pattern of a single-output
// block, streams {pattern, bit} records and compacts the response.
module exhaustive_sweep_capture
   import sweep_pkg::*;
#(
   parameter int unsigned          N_WIDTH       = 8,
   parameter int unsigned          SETTLE_CYCLES = 1,
   parameter int unsigned          SIG_WIDTH     = 16,
   parameter logic [SIG_WIDTH-1:0] SIG_POLY      = SIG_POLY_DEFAULT,
   parameter logic [SIG_WIDTH-1:0] SIG_SEED      = SIG_SEED_DEFAULT
) (
   input  logic                       CK,
   input  logic                       reset,
   input  logic                       start,
   output logic [N_WIDTH-1:0]         pat_out,
   input  logic                       dut_out,
   exhaustive_sweep_capture_if.master rec,
   output logic                       busy,
   output logic                       done,
   output logic [SIG_WIDTH-1:0]       signature,
   output logic [N_WIDTH:0]           ones_count
);

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   sweep_state_e state, state_next;
   logic [3:0]   settle_cnt;
   logic         start_sweep;
   logic         sample;
   logic         accept;
   logic         last_pat;

   assign last_pat = (pat_out == '1);

   always_ff @(posedge CK) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next  = state;
      start_sweep = 1'b0;
      sample      = 1'b0;
      accept      = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               start_sweep = 1'b1;
               state_next  = DRIVE;
            end
         end
         DRIVE: begin
            if (settle_cnt == SETTLE_LAST) begin
               sample     = 1'b1;
               state_next = EMIT;
            end
         end
         EMIT: begin
            if (rec.rec_valid && rec.rec_ready) begin
               accept     = 1'b1;
               state_next = last_pat ? DONE : DRIVE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // The all-ones pattern ends the sweep instead of wrapping pat_out to zero.
   always_ff @(posedge CK) begin
      if (reset) begin
         pat_out         <= '0;
         settle_cnt      <= '0;
         rec.rec_valid   <= 1'b0;
         rec.rec_pattern <= '0;
         rec.rec_bit     <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
         ones_count      <= '0;
      end else begin
         if (start_sweep) begin
            pat_out    <= '0;
            settle_cnt <= '0;
            ones_count <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
         end
         if (state == DRIVE) begin
            settle_cnt <= settle_cnt + 1'b1;
         end
         if (sample) begin
            rec.rec_valid   <= 1'b1;
            rec.rec_pattern <= pat_out;
            rec.rec_bit     <= dut_out;
            if (dut_out) begin
               ones_count <= ones_count + 1'b1;
            end
         end
         if (accept) begin
            rec.rec_valid <= 1'b0;
            if (last_pat) begin
               busy <= 1'b0;
               done <= 1'b1;
            end else begin
               pat_out    <= pat_out + 1'b1;
               settle_cnt <= '0;
            end
         end
      end
   end

   sweep_misr #(
      .SIG_WIDTH  (SIG_WIDTH),
      .DATA_WIDTH (N_WIDTH + 1),
      .SIG_POLY   (SIG_POLY),
      .SIG_SEED   (SIG_SEED)
   ) u_misr (
      .CK    (CK),
      .reset (reset),
      .seed  (start_sweep),
      .en    (sample),
      .data  ({pat_out, dut_out}),
      .sig   (signature)
   );

endmodule

// File: tb/tb_exhaustive_sweep_capture.sv
// Bench for exhaustive_sweep_capture: two instances (settle 1 and 3) driven
// against truth tables, checked against an arithmetic model of the sweep.
module tb_exhaustive_sweep_capture;
   import sweep_pkg::*;

   logic CK = 1'b0;
   always #5 CK = ~CK;

   logic        reset, start1, start3, ready, sel;
   logic [7:0]  pat1, pat3;
   logic        dout1, dout3;
   logic        busy1, busy3, done1, done3;
   logic [15:0] sig1, sig3;
   logic [8:0]  ones1, ones3;
   logic        tt [0:255];

   exhaustive_sweep_capture_if #(.N_WIDTH(8)) rif1 ();
   exhaustive_sweep_capture_if #(.N_WIDTH(8)) rif3 ();

   assign rif1.rec_ready = ready;
   assign rif3.rec_ready = ready;
   assign dout1 = tt[pat1];
   assign dout3 = tt[pat3];

   exhaustive_sweep_capture #(.N_WIDTH(8), .SETTLE_CYCLES(1), .SIG_WIDTH(16)) dut1 (
      .CK(CK), .reset(reset), .start(start1), .pat_out(pat1), .dut_out(dout1),
      .rec(rif1), .busy(busy1), .done(done1), .signature(sig1), .ones_count(ones1)
   );

   exhaustive_sweep_capture #(.N_WIDTH(8), .SETTLE_CYCLES(3), .SIG_WIDTH(16)) dut3 (
      .CK(CK), .reset(reset), .start(start3), .pat_out(pat3), .dut_out(dout3),
      .rec(rif3), .busy(busy3), .done(done3), .signature(sig3), .ones_count(ones3)
   );

   logic [7:0]  s_pat, s_rpat;
   logic        s_valid, s_rbit, s_busy, s_done;
   logic [15:0] s_sig;
   logic [8:0]  s_ones;

   assign s_pat   = sel ? pat3 : pat1;
   assign s_rpat  = sel ? rif3.rec_pattern : rif1.rec_pattern;
   assign s_valid = sel ? rif3.rec_valid : rif1.rec_valid;
   assign s_rbit  = sel ? rif3.rec_bit : rif1.rec_bit;
   assign s_busy  = sel ? busy3 : busy1;
   assign s_done  = sel ? done3 : done1;
   assign s_sig   = sel ? sig3 : sig1;
   assign s_ones  = sel ? ones3 : ones1;

   int compared = 0;
   int mismatched = 0;
   int cyc = 0;
   int cyc0;
   sweep_record_t recq[$];

   // Records are taken mid-cycle when the coming edge will accept them.
   always @(negedge CK) begin
      if (!reset && s_valid && ready) begin
         recq.push_back('{pattern: s_rpat, out_bit: s_rbit});
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge CK);
      #1;
      cyc++;
   endtask

   task automatic set_mode(input int m);
      for (int p = 0; p < 256; p++) begin
         logic [7:0] pv;
         pv = 8'(p);
         case (m)
            0:       tt[p] = 1'b0;
            1:       tt[p] = pv[0];
            2:       tt[p] = ^pv;
            3:       tt[p] = 1'b1;
            default: tt[p] = 1'($urandom_range(0, 1));
         endcase
      end
   endtask

   function automatic logic [15:0] model_sig();
      logic [15:0] s;
      s = 16'hFFFF;
      for (int p = 0; p < 256; p++) begin
         logic [8:0] word;
         word = {8'(p), tt[p]};
         s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {7'b0, word};
      end
      return s;
   endfunction

   function automatic int model_ones();
      int n;
      n = 0;
      for (int p = 0; p < 256; p++) n += int'(tt[p]);
      return n;
   endfunction

   task automatic pulse_start();
      recq.delete();
      if (sel) start3 = 1'b1;
      else     start1 = 1'b1;
      step();
      start1 = 1'b0;
      start3 = 1'b0;
      cyc0 = cyc;
   endtask

   task automatic wait_done(input int limit);
      int n;
      n = 0;
      while (!s_done && n < limit) begin
         step();
         n++;
      end
      chk("done_reached", 32'(s_done), 32'd1);
   endtask

   task automatic wait_pat(input int p, input int limit);
      int n;
      n = 0;
      while (s_pat != 8'(p) && n < limit) begin
         step();
         n++;
      end
      chk("pat_reached", 32'(s_pat), 32'(p));
   endtask

   task automatic check_records();
      int bad;
      bad = 0;
      chk("rec_count", 32'(recq.size()), 32'd256);
      for (int i = 0; i < recq.size() && i < 256; i++) begin
         if (recq[i].pattern !== 8'(i) || recq[i].out_bit !== tt[i]) bad++;
      end
      chk("rec_content_bad", 32'(bad), 32'd0);
   endtask

   task automatic check_results(input int exp_ones);
      chk("ones_count", 32'(s_ones), 32'(exp_ones));
      chk("signature", 32'(s_sig), 32'(model_sig()));
      chk("busy_after_done", 32'(s_busy), 32'd0);
      check_records();
   endtask

   typedef struct {
      int mode;
      logic sel;
      int exp_ones;
      int exp_cycles;
   } vec_t;

   vec_t        tbl [5];
   logic [15:0] sig_lsb3, sig_par3;

   initial begin
      tbl[0] = '{mode: 0, sel: 1'b0, exp_ones: 0,   exp_cycles: 512};
      tbl[1] = '{mode: 1, sel: 1'b0, exp_ones: 128, exp_cycles: 512};
      tbl[2] = '{mode: 1, sel: 1'b1, exp_ones: 128, exp_cycles: 1024};
      tbl[3] = '{mode: 2, sel: 1'b1, exp_ones: 128, exp_cycles: 1024};
      tbl[4] = '{mode: 3, sel: 1'b0, exp_ones: 256, exp_cycles: 512};
      sig_lsb3 = '0;
      sig_par3 = '0;

      reset = 1'b1; start1 = 1'b0; start3 = 1'b0; ready = 1'b1; sel = 1'b0;
      set_mode(0);
      repeat (3) step();

      // Reset state of both instances
      for (int k = 0; k < 2; k++) begin
         sel = 1'(k);
         #0;
         chk("rst_busy", 32'(s_busy), 32'd0);
         chk("rst_done", 32'(s_done), 32'd0);
         chk("rst_pat", 32'(s_pat), 32'd0);
         chk("rst_valid", 32'(s_valid), 32'd0);
         chk("rst_sig", 32'(s_sig), 32'hFFFF);
         chk("rst_ones", 32'(s_ones), 32'd0);
      end
      sel = 1'b0;

      // Reset wins over a simultaneous start
      start1 = 1'b1;
      step();
      start1 = 1'b0;
      reset  = 1'b0;
      chk("rst_vs_start_busy", 32'(busy1), 32'd0);
      step();
      chk("rst_vs_start_idle", 32'(busy1), 32'd0);

      for (int i = 0; i < 5; i++) begin
         set_mode(tbl[i].mode);
         sel = tbl[i].sel;
         pulse_start();
         chk("busy_after_start", 32'(s_busy), 32'd1);
         wait_done(4000);
         chk("sweep_cycles", 32'(cyc - cyc0), 32'(tbl[i].exp_cycles));
         check_results(tbl[i].exp_ones);
         if (tbl[i].sel && tbl[i].mode == 1) sig_lsb3 = s_sig;
         if (tbl[i].sel && tbl[i].mode == 2) sig_par3 = s_sig;
      end
      compared++;
      if (sig_par3 === sig_lsb3) begin
         mismatched++;
         $display("FAIL sig_distinct: parity sig %h equals lsb sig %h, required different", sig_par3, sig_lsb3);
      end

      // Backpressure: stall five cycles on the record for pattern 3
      sel = 1'b0;
      set_mode(4);
      pulse_start();
      begin
         int n;
         n = 0;
         while (!(s_valid && s_rpat == 8'd3) && n < 100) begin
            step();
            n++;
         end
      end
      chk("stall_reach", 32'({s_valid, s_rpat}), 32'h103);
      ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("stall_valid", 32'(s_valid), 32'd1);
         chk("stall_rpat", 32'(s_rpat), 32'd3);
         chk("stall_rbit", 32'(s_rbit), 32'(tt[3]));
         chk("stall_pat", 32'(s_pat), 32'd3);
         chk("stall_ones", 32'(s_ones), 32'(int'(tt[0]) + int'(tt[1]) + int'(tt[2]) + int'(tt[3])));
      end
      ready = 1'b1;
      wait_done(4000);
      chk("stall_cycles", 32'(cyc - cyc0), 32'd517);
      check_results(model_ones());

      // Random truth table with random backpressure on the settle-3 instance
      sel = 1'b1;
      set_mode(4);
      pulse_start();
      begin
         int n;
         n = 0;
         while (!s_done && n < 20000) begin
            ready = ($urandom_range(0, 3) != 0);
            step();
            n++;
         end
      end
      ready = 1'b1;
      chk("rand_done", 32'(s_done), 32'd1);
      check_results(model_ones());

      // Reset in the middle of a sweep, then a clean sweep from pattern 0
      sel = 1'b0;
      set_mode(1);
      pulse_start();
      wait_pat(100, 1000);
      reset = 1'b1;
      step();
      chk("mid_rst_busy", 32'(s_busy), 32'd0);
      chk("mid_rst_done", 32'(s_done), 32'd0);
      chk("mid_rst_pat", 32'(s_pat), 32'd0);
      chk("mid_rst_valid", 32'(s_valid), 32'd0);
      chk("mid_rst_ones", 32'(s_ones), 32'd0);
      chk("mid_rst_sig", 32'(s_sig), 32'hFFFF);
      reset = 1'b0;
      step();
      pulse_start();
      wait_done(4000);
      chk("post_rst_cycles", 32'(cyc - cyc0), 32'd512);
      check_results(128);

      // Start while busy is ignored
      set_mode(2);
      pulse_start();
      wait_pat(40, 1000);
      start1 = 1'b1;
      step();
      start1 = 1'b0;
      chk("busy_start_pat", 32'(s_pat), 32'd40);
      wait_done(4000);
      chk("busy_start_cycles", 32'(cyc - cyc0), 32'd512);
      check_results(128);

      // DONE holds its results, then start restarts the sweep
      repeat (3) step();
      chk("done_hold", 32'(s_done), 32'd1);
      chk("done_hold_sig", 32'(s_sig), 32'(model_sig()));
      chk("done_hold_ones", 32'(s_ones), 32'd128);
      set_mode(3);
      pulse_start();
      chk("restart_done", 32'(s_done), 32'd0);
      chk("restart_pat", 32'(s_pat), 32'd0);
      chk("restart_busy", 32'(s_busy), 32'd1);
      chk("restart_ones", 32'(s_ones), 32'd0);
      wait_done(4000);
      chk("restart_cycles", 32'(cyc - cyc0), 32'd512);
      check_results(256);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/exhaustive_sweep_capture.md
Name: exhaustive_sweep_capture

Overview:
- Hardware sequencer that replaces a software exhaustive-sweep bench for one single-output combinational block under test.
- Drives every pattern 0..2^N_WIDTH-1 in ascending order onto the block inputs, waits a settle interval, and samples the block's single output bit.
- Streams each {pattern, bit} record to a downstream logger over a valid/ready handshake.
- Compacts the full response into a MISR signature plus a ones count, used for trojan-detection comparison against a golden run.

Parameters:
- N_WIDTH, 8, width of the stimulus pattern (number of block inputs).
- SETTLE_CYCLES, 1, cycles a pattern is held before its output is sampled; legal range 1..15.
- SIG_WIDTH, 16, MISR width; must be >= N_WIDTH+1.
- SIG_POLY, 16'h1021, MISR feedback taps.
- SIG_SEED, 16'hFFFF, MISR value after reset and on start.

Ports:
- CK  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a sweep; honoured only in IDLE or DONE.
- pat_out  out  N_WIDTH  stimulus pattern to the block under test.
- dut_out  in  1  single output bit of the block under test.
- rec_valid  out  1  a record is available.
- rec_ready  in  1  logger accepts the record.
- rec_pattern  out  N_WIDTH  pattern of the current record.
- rec_bit  out  1  sampled output bit of the current record.
- busy  out  1  sweep in progress.
- done  out  1  sweep complete; results valid.
- signature  out  SIG_WIDTH  MISR value.
- ones_count  out  N_WIDTH+1  number of patterns whose sampled bit was 1.

Behaviour:
- Reset values (applied on any reset edge, including mid-sweep): state=IDLE; pat_out=0; rec_valid=0; rec_pattern=0; rec_bit=0; busy=0; done=0; signature=SIG_SEED; ones_count=0; settle counter=0.
- States: IDLE, DRIVE, EMIT, DONE.
- IDLE / DONE:
  - start=1 at an edge moves to DRIVE and sets pat_out=0, settle counter=0, signature=SIG_SEED, ones_count=0, done=0, busy=1.
  - start=0: hold state. DONE keeps done=1 and keeps the results stable.
- DRIVE:
  - pat_out is held; the settle counter increments each cycle.
  - On the edge that completes the SETTLE_CYCLES-th DRIVE cycle:
    - rec_bit<=dut_out and rec_pattern<=pat_out.
    - ones_count increments when dut_out=1.
    - signature<=(sig<<1) ^ (sig[MSB] ? SIG_POLY : 0) ^ zero_extend({pat_out, dut_out}).
    - rec_valid<=1; go to EMIT.
- EMIT:
  - rec_valid=1; rec_pattern, rec_bit and pat_out are held stable.
  - The MISR and ones_count are not updated again for this pattern, whatever the backpressure.
  - On rec_valid&&rec_ready: rec_valid<=0.
    - If pat_out is all ones: busy<=0, done<=1, go to DONE.
    - Otherwise: pat_out<=pat_out+1, settle counter<=0, go to DRIVE.
- Timing: each pattern takes SETTLE_CYCLES+1 cycles when rec_ready is held high. A full sweep takes 2^N_WIDTH*(SETTLE_CYCLES+1) cycles from the start edge to done=1.
- start while busy: ignored; no restart and no effect on counts.
- Wrap-around: pat_out never wraps back to 0 within a sweep; the all-ones pattern terminates the sweep.
- ones_count is N_WIDTH+1 bits wide so that it can represent 2^N_WIDTH without overflow.
- rec_ready high outside EMIT: no effect.
- Reset asserted together with start: reset wins.

Decomposition:
- Shared package sweep_pkg holds:
  - the state enum typedef (IDLE/DRIVE/EMIT/DONE);
  - the default SIG_POLY and SIG_SEED constants;
  - a record struct {pattern, bit}.
- One sub-module, sweep_misr, holds the signature register and implements seed, enable and step. This isolates it for reuse by a future multi-output variant.
- The FSM, the pattern counter and the settle counter stay in the top level.

Test Plan:
- Tied-zero output: SETTLE_CYCLES=1, dut_out=0, rec_ready=1, start pulse at edge e0.
  - 256 records, rec_pattern 0..255 in order, rec_bit all 0.
  - done=1 after edge e0+512; ones_count=0; signature equals the bit-accurate model.
- LSB loopback: dut_out=pat_out[0].
  - ones_count=128; each record has rec_bit equal to rec_pattern[0].
- Parity output: dut_out=^pat_out, with SETTLE_CYCLES=3.
  - ones_count=128; done after 1024 cycles; signature matches the model; it must differ from the LSB-loopback signature.
- Backpressure: rec_ready=0 for 5 cycles while rec_pattern=3.
  - rec_valid, rec_pattern=3, rec_bit and pat_out=3 stay stable.
  - No double count; the total sweep is 5 cycles longer; final ones_count and signature are identical to the unstalled run.
- Reset mid-sweep at pat_out=100: busy=0, done=0, pat_out=0, rec_valid=0, ones_count=0 and signature=16'hFFFF on the next cycle. A new start then sweeps again from pattern 0.
- Start handling:
  - start pulsed at pat_out=40: ignored, and the sweep result is unchanged.
  - start pulsed in DONE: done=0 and pat_out=0 one cycle later, and the sweep restarts.
